// File: rtl/adc_sample_sequencer.sv
// Frame sequencer for the dual-channel SPI ADC connector: paces frames, drives the
// load/select handshake, and buffers captured A/B sample pairs in a small FWFT FIFO.
module adc_sample_sequencer #(
  parameter int unsigned PERIOD        = 200,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned FRAME_TIMEOUT = 64,
  parameter int unsigned DEPTH         = 4,
  parameter logic        CPOL_VAL      = 1'b0,
  parameter logic        CPHA_VAL      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] ctrl_word,
  output logic        ss_n,
  output logic        cpol,
  output logic        cpha,
  output logic        load_cmd,
  output logic [15:0] ctrl_out,
  input  logic        loaded,
  input  logic        finished,
  input  logic [13:0] data_a,
  input  logic [13:0] data_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_a,
  output logic [13:0] out_b,
  output logic [4:0]  fifo_count,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned PerW = $clog2(PERIOD);
  localparam int unsigned CntW = $clog2(FRAME_TIMEOUT + GAP_CYCLES + 17);
  localparam int unsigned AW   = $clog2(DEPTH);

  localparam logic [PerW-1:0] PerLast   = PerW'(PERIOD - 1);
  localparam logic [CntW-1:0] LoadLast  = CntW'(15);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StFrame   = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StGap     = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PerW-1:0] per_q, per_d;
  logic            pend_q, pend_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic            tick, push, pop, push_ok, full, tout_set, ovf_set;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [4:0]      count_q, count_d;
  logic [27:0]     mem_q [DEPTH];
  logic [27:0]     head, hold_q;
  logic            ovf_q, ovf_d, tout_q, tout_d;

  always_comb begin
    tick  = enable && (per_q == PerLast);
    per_d = (!enable || tick) ? '0 : per_q + PerW'(1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    pend_d   = pend_q;
    ctrl_d   = ctrl_q;
    tout_set = 1'b0;
    push     = 1'b0;
    // Only one start may be remembered while a frame is in flight.
    if (tick && (state_q != StIdle)) pend_d = 1'b1;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable && (tick || pend_q)) begin
          state_d = StLoad;
          ctrl_d  = ctrl_word;
          pend_d  = 1'b0;
        end
      end
      StLoad: begin
        if (loaded) begin
          state_d = StFrame;
          cnt_d   = '0;
        end else if (cnt_q == LoadLast) begin
          state_d  = StGap;
          cnt_d    = '0;
          tout_set = 1'b1;
        end
      end
      StFrame: begin
        if (finished) begin
          state_d = StCapture;
          cnt_d   = '0;
        end else if (cnt_q == FrameLast) begin
          state_d  = StGap;
          cnt_d    = '0;
          tout_set = 1'b1;
        end
      end
      StCapture: begin
        push    = 1'b1;
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (!enable) pend_d = 1'b0;
  end

  always_comb begin
    out_valid = (count_q != 5'd0);
    full      = (count_q == 5'(DEPTH));
    pop       = out_valid && out_ready;
    push_ok   = push && (!full || pop);
    ovf_set   = push && full && !pop;
    wr_d      = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    count_d   = count_q + 5'(push_ok) - 5'(pop);
    // A set event in the same cycle as err_clr keeps the flag high.
    ovf_d     = ovf_set | (ovf_q & ~err_clr);
    tout_d    = tout_set | (tout_q & ~err_clr);
    head      = mem_q[rd_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      ctrl_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      ctrl_q  <= ctrl_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
      if (out_valid) hold_q <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {data_a, data_b};
  end

  // Outputs keep the last shown entry once the FIFO drains.
  always_comb begin
    ss_n        = !((state_q == StFrame) || (state_q == StCapture));
    load_cmd    = (state_q == StLoad);
    busy        = (state_q != StIdle);
    cpol        = CPOL_VAL;
    cpha        = CPHA_VAL;
    ctrl_out    = ctrl_q;
    fifo_count  = count_q;
    overflow    = ovf_q;
    timeout_err = tout_q;
    out_a       = out_valid ? head[27:14] : hold_q[27:14];
    out_b       = out_valid ? head[13:0] : hold_q[13:0];
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer: behavioural connector model plus a
// scoreboard of expected sample pairs that is compared whenever the consumer pops.
module tb_adc_sample_sequencer;

  localparam int Depth  = 4;
  localparam int Period = 200;

  logic        clk = 1'b0;
  logic        reset, enable, loaded, finished, out_ready, err_clr;
  logic [15:0] ctrl_word, ctrl_out;
  logic [13:0] data_a, data_b, out_a, out_b;
  logic        ss_n, cpol, cpha, load_cmd, out_valid, busy, overflow, timeout_err;
  logic [4:0]  fifo_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pops     = 0;
  bit          never_finish = 1'b0;
  bit          fin_prev = 1'b0;
  logic [27:0] exp_q [$];

  always #5 clk = ~clk;

  adc_sample_sequencer #(
    .PERIOD        (Period),
    .GAP_CYCLES    (4),
    .FRAME_TIMEOUT (64),
    .DEPTH         (Depth),
    .CPOL_VAL      (1'b0),
    .CPHA_VAL      (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ctrl_word   (ctrl_word),
    .ss_n        (ss_n),
    .cpol        (cpol),
    .cpha        (cpha),
    .load_cmd    (load_cmd),
    .ctrl_out    (ctrl_out),
    .loaded      (loaded),
    .finished    (finished),
    .data_a      (data_a),
    .data_b      (data_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // Connector model: loaded 2 cycles after load_cmd, finished 33 cycles after ss_n falls.
  initial begin : connector
    int ld_cnt;
    int ss_cnt;
    ld_cnt   = 0;
    ss_cnt   = 0;
    loaded   = 1'b0;
    finished = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ld_cnt   = load_cmd ? ld_cnt + 1 : 0;
      loaded   = (ld_cnt > 2);
      ss_cnt   = !ss_n ? ss_cnt + 1 : 0;
      finished = !never_finish && (ss_cnt == 34);
    end
  end

  // Scoreboard: push in the capture cycle (unless full without pop), compare on each pop.
  always @(negedge clk) begin : monitor
    int sz;
    bit pop_m;
    if (reset) begin
      exp_q.delete();
      fin_prev = 1'b0;
    end else begin
      sz    = exp_q.size();
      pop_m = (sz > 0) && out_ready;
      if (pop_m) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_a, out_b} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL pop_data: got valid=%b a=%h b=%h, want valid=1 a=%h b=%h",
                   out_valid, out_a, out_b, exp_q[0][27:14], exp_q[0][13:0]);
        end
        void'(exp_q.pop_front());
        pops++;
      end
      if (fin_prev && (sz < Depth || pop_m)) exp_q.push_back({data_a, data_b});
      fin_prev = finished && !ss_n;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ss(input logic lvl, input int maxc, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (ss_n === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic one_frame(output bit ok);
    bit ok0, ok1;
    int n;
    wait_ss(1'b0, 400, ok0, n);
    wait_ss(1'b1, 100, ok1, n);
    ok = ok0 && ok1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    ctrl_word = 16'h0000;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    data_a    = '0;
    data_b    = '0;
    #3;
    n_checks++;
    if ({ss_n, load_cmd, busy, ctrl_out} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ss_n=%b load=%b busy=%b ctrl=%h, want 1 0 0 0000",
               ss_n, load_cmd, busy, ctrl_out);
    end
    n_checks++;
    if ({out_valid, fifo_count, out_a, out_b} !== {1'b0, 5'd0, 14'h0, 14'h0}) begin
      n_fail++;
      $display("FAIL reset_fifo: got valid=%b cnt=%0d a=%h b=%h, want 0 0 0 0",
               out_valid, fifo_count, out_a, out_b);
    end
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if ({overflow, timeout_err, cpol, cpha, ss_n} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: got ovf=%b tout=%b cpol=%b cpha=%b ss_n=%b, want 0 0 0 0 1",
               overflow, timeout_err, cpol, cpha, ss_n);
    end
    enable    = 1'b1;
    ctrl_word = 16'hA5F0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int n, n_low;
    logic v_cap;
    data_a = 14'h1234;
    data_b = 14'h0ABC;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (load_cmd === 1'b1) break;
    end
    n_checks++;
    if (load_cmd !== 1'b1 || ctrl_out !== 16'hA5F0 || ss_n !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: got load=%b ctrl=%h ss_n=%b, want 1 a5f0 1",
               load_cmd, ctrl_out, ss_n);
    end
    wait_ss(1'b0, 50, ok, n);
    n_low = 0;
    v_cap = 1'b0;
    while (ss_n === 1'b0 && n_low < 100) begin
      v_cap = out_valid;
      @(negedge clk);
      n_low++;
    end
    n_checks++;
    if (!ok || n_low != 35 || v_cap !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_frame: got ok=%b low_cycles=%0d valid_in_capture=%b, want 1 35 0",
               ok, n_low, v_cap);
    end
    n_checks++;
    if ({out_valid, fifo_count, out_a, out_b} !== {1'b1, 5'd1, 14'h1234, 14'h0ABC}) begin
      n_fail++;
      $display("FAIL basic_sample: got valid=%b cnt=%0d a=%h b=%h, want 1 1 1234 0abc",
               out_valid, fifo_count, out_a, out_b);
    end
    step();
    out_ready = 1'b1;
    wait_ss(1'b0, 300, ok, n);
    n_checks++;
    if (!ok || n_low + n != Period) begin
      n_fail++;
      $display("FAIL basic_period: got ok=%b interval=%0d, want 1 %0d", ok, n_low + n, Period);
    end
    wait_ss(1'b1, 100, ok, n);
  endtask

  task automatic test_overflow();
    bit ok;
    int exp_cnt;
    step();
    out_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      step();
      data_a  = 14'h0100 + 14'(f);
      data_b  = 14'h2200 + 14'(f);
      one_frame(ok);
      exp_cnt = (f < 4) ? f + 1 : 4;
      n_checks++;
      if (!ok || fifo_count !== 5'(exp_cnt) || overflow !== (f >= 4)) begin
        n_fail++;
        $display("FAIL overflow_fill%0d: got ok=%b cnt=%0d ovf=%b, want 1 %0d %b",
                 f, ok, fifo_count, overflow, exp_cnt, (f >= 4));
      end
    end
    step();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({out_valid, fifo_count, out_a, out_b} !== {1'b0, 5'd0, 14'h0103, 14'h2203}) begin
      n_fail++;
      $display("FAIL overflow_drain: got valid=%b cnt=%0d a=%h b=%h, want 0 0 0103 2203",
               out_valid, fifo_count, out_a, out_b);
    end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b, want 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    bit ok, okf;
    int n;
    step();
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      step();
      data_a = 14'h0300 + 14'(f);
      data_b = 14'h0400 + 14'(f);
      one_frame(ok);
    end
    n_checks++;
    if (!ok || fifo_count !== 5'd4) begin
      n_fail++;
      $display("FAIL fullpop_fill: got ok=%b cnt=%0d, want 1 4", ok, fifo_count);
    end
    step();
    data_a = 14'h03AA;
    data_b = 14'h0555;
    wait_ss(1'b0, 400, ok, n);
    okf = 1'b0;
    n   = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (finished === 1'b1) begin
        okf = 1'b1;
        break;
      end
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!okf || fifo_count !== 5'd4 || overflow !== 1'b0 || out_a !== 14'h0301) begin
      n_fail++;
      $display("FAIL fullpop_capture: got ok=%b cnt=%0d ovf=%b head_a=%h, want 1 4 0 0301",
               okf, fifo_count, overflow, out_a);
    end
    step();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (fifo_count !== 5'd0 || out_a !== 14'h03AA || out_b !== 14'h0555) begin
      n_fail++;
      $display("FAIL fullpop_tail: got cnt=%0d a=%h b=%h, want 0 03aa 0555",
               fifo_count, out_a, out_b);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n, n_low, n_gap, p0;
    step();
    out_ready    = 1'b1;
    never_finish = 1'b1;
    wait_ss(1'b0, 400, ok, n);
    n_low = 0;
    while (ss_n === 1'b0 && n_low < 100) begin
      @(negedge clk);
      n_low++;
    end
    n_checks++;
    if (!ok || n_low != 64 || timeout_err !== 1'b1 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL timeout_frame: got ok=%b low=%0d tout=%b cnt=%0d, want 1 64 1 0",
               ok, n_low, timeout_err, fifo_count);
    end
    n_gap = 0;
    while (busy === 1'b1 && n_gap < 20) begin
      @(negedge clk);
      n_gap++;
    end
    n_checks++;
    if (n_gap != 4) begin
      n_fail++;
      $display("FAIL timeout_gap: got %0d gap cycles, want 4", n_gap);
    end
    step();
    never_finish = 1'b0;
    data_a = 14'h0A0A;
    data_b = 14'h0B0B;
    p0 = pops;
    one_frame(ok);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (!ok || pops != p0 + 1) begin
      n_fail++;
      $display("FAIL timeout_recover: got ok=%b pops=%0d, want 1 %0d", ok, pops, p0 + 1);
    end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b, want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    step();
    out_ready = 1'b0;
    data_a = 14'h0777;
    data_b = 14'h1888;
    one_frame(ok);
    n_checks++;
    if (!ok || fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got ok=%b cnt=%0d, want 1 1", ok, fifo_count);
    end
    wait_ss(1'b0, 400, ok, n);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ss_n, load_cmd, busy, out_valid, fifo_count} !== {4'b1000, 5'd0}) begin
      n_fail++;
      $display("FAIL rstmid_async: got ss_n=%b load=%b busy=%b valid=%b cnt=%0d, want 1 0 0 0 0",
               ss_n, load_cmd, busy, out_valid, fifo_count);
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (load_cmd === 1'b1) break;
    end
    n_checks++;
    if (load_cmd !== 1'b1 || n != Period) begin
      n_fail++;
      $display("FAIL rstmid_restart: got load=%b after %0d cycles, want 1 after %0d",
               load_cmd, n, Period);
    end
    step();
    out_ready = 1'b1;
    wait_ss(1'b1, 100, ok, n);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n, p0, n_act;
    step();
    data_a = 14'h1111;
    data_b = 14'h2222;
    #0;
    p0 = pops;
    wait_ss(1'b0, 400, ok, n);
    step();
    enable = 1'b0;
    wait_ss(1'b1, 100, ok, n);
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (!ok || pops != p0 + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_finish: got ok=%b pops=%0d busy=%b, want 1 %0d 0",
               ok, pops, busy, p0 + 1);
    end
    n_act = 0;
    repeat (450) begin
      @(negedge clk);
      if (!ss_n || load_cmd || busy) n_act++;
    end
    n_checks++;
    if (n_act != 0) begin
      n_fail++;
      $display("FAIL endrop_idle: got %0d active cycles, want 0", n_act);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
